// File: rtl/barcode_tx.sv
// Barcode stimulus transmitter: start pulse plus eight MSB-first pulse-width bits on BC.
// Optional ID range check is enabled by defining BC_TX_ID_CHK_EN.
module barcode_tx #(
   parameter int T_CYC = 512
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       send,
   input  logic [7:0] ID,
   output logic       BC,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START_LO,
      S_START_HI,
      S_BIT_LO,
      S_BIT_HI,
      S_GUARD
   } state_t;

   // Terminal counts: each phase lasts (constant + 1) cycles from cnt = 0.
   localparam logic [21:0] CNT_T     = 22'(T_CYC - 1);
   localparam logic [21:0] CNT_HALF  = 22'(T_CYC / 2 - 1);
   localparam logic [21:0] CNT_3HALF = 22'(3 * T_CYC / 2 - 1);
   localparam logic [21:0] CNT_2T    = 22'(2 * T_CYC - 1);

   state_t      state_q, state_d;
   logic [21:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  sr_q, sr_d;
   logic        bc_q, bc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
`ifdef BC_TX_ID_CHK_EN
   logic        err_q, err_d;
`endif

   logic [21:0] lo_end, hi_end;

   // A 1-bit is a short low followed by a long high; a 0-bit the reverse.
   assign lo_end = sr_q[7] ? CNT_HALF : CNT_3HALF;
   assign hi_end = sr_q[7] ? CNT_3HALF : CNT_HALF;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 22'd1;
      bit_idx_d = bit_idx_q;
      sr_d      = sr_q;
      bc_d      = bc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
`ifdef BC_TX_ID_CHK_EN
      err_d     = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            bc_d  = 1'b1;
            if (send) begin
`ifdef BC_TX_ID_CHK_EN
               if (ID[7:6] != 2'b00) begin
                  err_d = 1'b1;
               end else begin
                  err_d     = 1'b0;
                  sr_d      = ID;
                  bit_idx_d = '0;
                  state_d   = S_START_LO;
                  bc_d      = 1'b0;
                  busy_d    = 1'b1;
               end
`else
               sr_d      = ID;
               bit_idx_d = '0;
               state_d   = S_START_LO;
               bc_d      = 1'b0;
               busy_d    = 1'b1;
`endif
            end
         end
         S_START_LO: begin
            if (cnt_q == CNT_T) begin
               state_d = S_START_HI;
               cnt_d   = '0;
               bc_d    = 1'b1;
            end
         end
         S_START_HI: begin
            if (cnt_q == CNT_T) begin
               state_d = S_BIT_LO;
               cnt_d   = '0;
               bc_d    = 1'b0;
            end
         end
         S_BIT_LO: begin
            if (cnt_q == lo_end) begin
               state_d = S_BIT_HI;
               cnt_d   = '0;
               bc_d    = 1'b1;
            end
         end
         S_BIT_HI: begin
            if (cnt_q == hi_end) begin
               cnt_d     = '0;
               sr_d      = {sr_q[6:0], 1'b0};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_GUARD;
               end else begin
                  state_d = S_BIT_LO;
                  bc_d    = 1'b0;
               end
            end
         end
         S_GUARD: begin
            if (cnt_q == CNT_2T) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bc_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         sr_q      <= '0;
         bc_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef BC_TX_ID_CHK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         sr_q      <= sr_d;
         bc_q      <= bc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef BC_TX_ID_CHK_EN
         err_q     <= err_d;
`endif
      end
   end

   assign BC   = bc_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef BC_TX_ID_CHK_EN
   assign err  = err_q;
`else
   assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_barcode_tx.sv
// Bench for barcode_tx: BC waveform compared cycle by cycle against a pulse-width model.
// Define BC_TX_ID_CHK_EN to exercise the ID reject path as well.
module tb_barcode_tx;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       send = 1'b0;
   logic [7:0] id_in = 8'h00;
   logic       bc, busy, done, err;

   int tests = 0;
   int fails = 0;

   logic [0:0] exp_q[$];

   barcode_tx #(.T_CYC(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .send  (send),
      .ID    (id_in),
      .BC    (bc),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   // Expected BC level for each of the 20*T cycles of a frame.
   task automatic build_exp(input logic [7:0] id);
      int lo;
      exp_q.delete();
      for (int i = 0; i < T; i++) exp_q.push_back(1'b0);
      for (int i = 0; i < T; i++) exp_q.push_back(1'b1);
      for (int b = 7; b >= 0; b--) begin
         lo = id[b] ? T / 2 : 3 * T / 2;
         for (int i = 0; i < lo; i++) exp_q.push_back(1'b0);
         for (int i = 0; i < 2 * T - lo; i++) exp_q.push_back(1'b1);
      end
      for (int i = 0; i < 2 * T; i++) exp_q.push_back(1'b1);
   endtask

   function automatic logic [7:0] valid_id(input logic [7:0] id);
`ifdef BC_TX_ID_CHK_EN
      return {2'b00, id[5:0]};
`else
      return id;
`endif
   endfunction

   // Raise send with id before an edge; afterwards scramble ID (and drop send unless held).
   task automatic start_frame(input logic [7:0] id, input bit hold, input logic [7:0] after_id);
      @(negedge clk);
      send  = 1'b1;
      id_in = id;
      @(posedge clk);
      #1;
      if (!hold) send = 1'b0;
      id_in = after_id;
   endtask

   // Called just after the accepting edge; inject >= 0 pulses send with a foreign ID mid-frame.
   task automatic check_frame(input string name, input logic [7:0] id, input int inject);
      build_exp(id);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         tests++;
         if (bc !== exp_q[i] || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s cyc %0d: bc/busy/done/err got %b%b%b%b exp %b100",
                     name, i, bc, busy, done, err, exp_q[i]);
         end
         if (i == inject) begin
            send  = 1'b1;
            id_in = ~id;
         end else if (inject >= 0 && i == inject + 1) begin
            send = 1'b0;
         end
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || bc !== 1'b1) begin
         fails++;
         $display("FAIL %s end: done/busy/bc got %b%b%b exp 101", name, done, busy, bc);
      end
   endtask

   task automatic test_reset();
      logic [7:0] id;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (bc !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_init: bc/busy/done/err got %b%b%b%b exp 1000", bc, busy, done, err);
      end
      rst_n = 1'b1;
      id = valid_id(8'($urandom));
      start_frame(id, 1'b0, 8'($urandom));
      repeat (5) @(negedge clk);
      tests++;
      if (bc !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL reset_pre: bc/busy got %b%b exp 01", bc, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (bc !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: bc/busy/done got %b%b%b exp 100", bc, busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (bc !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_abort: bc/busy/done got %b%b%b exp 100", bc, busy, done);
      end
      id = valid_id(8'($urandom));
      start_frame(id, 1'b0, 8'($urandom));
      check_frame("reset_fresh", id, -1);
   endtask

   task automatic test_id_2a();
      start_frame(8'h2A, 1'b0, 8'hFF);
      check_frame("id_2a", 8'h2A, -1);
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || bc !== 1'b1) begin
         fails++;
         $display("FAIL done_pulse: done/busy/bc got %b%b%b exp 001", done, busy, bc);
      end
   endtask

   task automatic test_random_ids();
      logic [7:0] id;
      for (int n = 0; n < 5; n++) begin
         id = valid_id(8'($urandom));
         start_frame(id, 1'b0, 8'($urandom));
         check_frame("random", id, -1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      start_frame(8'h00, 1'b1, 8'h00);
      check_frame("b2b_first", 8'h00, -1);
      id_in = 8'h3F;
      @(posedge clk);
      #1 send = 1'b0;
      id_in = 8'hA5;
      check_frame("b2b_second", 8'h3F, -1);
   endtask

   task automatic test_ignore_send();
      logic [7:0] id;
      id = valid_id(8'($urandom));
      build_exp(id);
      start_frame(id, 1'b0, 8'($urandom));
      // Third cycle of the first bit's high phase.
      check_frame("ignore_send", id, 2 * T + (id[7] ? T / 2 : 3 * T / 2) + 2);
   endtask

   task automatic test_id_check();
`ifdef BC_TX_ID_CHK_EN
      start_frame(8'hC1, 1'b0, 8'h00);
      for (int i = 0; i < 25 * T; i++) begin
         @(negedge clk);
         tests++;
         if (bc !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL id_reject cyc %0d: bc/busy/done/err got %b%b%b%b exp 1001",
                     i, bc, busy, done, err);
         end
      end
      start_frame(8'h01, 1'b0, 8'hC0);
      check_frame("id_after_reject", 8'h01, -1);
`else
      start_frame(8'hC1, 1'b0, 8'h00);
      check_frame("id_unchecked", 8'hC1, -1);
`endif
   endtask

   initial begin
      test_reset();
      test_id_2a();
      test_random_ids();
      test_back_to_back();
      test_ignore_send();
      test_id_check();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
